// File: rtl/memory_dbus_ctrl.sv
// rtl/memory_dbus_ctrl.sv - MEM-stage data bus controller: issues aligned loads/stores and extracts load data
module memory_dbus_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [63:0] in_alu,
  input  logic [4:0]  in_rd,
  input  logic        in_regwrite,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_ok,
  input  logic [63:0] dresp_data,
  output logic        stall_mem,
  output logic        out_valid,
  output logic [63:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_regwrite,
  output logic        out_misalign
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_next;
  logic        is_mem, aligned, issue;
  logic [7:0]  size_mask, strobe_calc;
  logic [63:0] data_calc, shifted, load_value;

  logic [63:0] a_addr;
  logic [1:0]  a_size;
  logic        a_unsigned;
  logic [7:0]  a_strobe;
  logic [63:0] a_data;
  logic [4:0]  a_rd;
  logic        a_regwrite;
  logic        a_load;

  always_comb begin
    is_mem      = in_valid && (in_load || in_store);
    aligned     = 1'b1;
    size_mask   = 8'h01;
    case (in_size)
      2'd0: begin aligned = 1'b1;                size_mask = 8'h01; end
      2'd1: begin aligned = ~in_addr[0];         size_mask = 8'h03; end
      2'd2: begin aligned = (in_addr[1:0] == 0); size_mask = 8'h0F; end
      default: begin aligned = (in_addr[2:0] == 0); size_mask = 8'hFF; end
    endcase
    issue       = (state == IDLE) && is_mem && aligned;
    strobe_calc = in_load ? 8'h00 : (size_mask << in_addr[2:0]);
    data_calc   = in_wdata << {in_addr[2:0], 3'b000};
  end

  // Lane extraction always uses the latched request, never the live inputs.
  always_comb begin
    shifted    = dresp_data >> {a_addr[2:0], 3'b000};
    load_value = shifted;
    case (a_size)
      2'd0: load_value = {{56{~a_unsigned & shifted[7]}},  shifted[7:0]};
      2'd1: load_value = {{48{~a_unsigned & shifted[15]}}, shifted[15:0]};
      2'd2: load_value = {{32{~a_unsigned & shifted[31]}}, shifted[31:0]};
      default: load_value = shifted;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (issue) state_next = BUSY;
      BUSY: if (dresp_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign dreq_valid  = (state == BUSY) && !reset;
  assign stall_mem   = !reset && (issue || ((state == BUSY) && !dresp_ok));
  assign dreq_addr   = a_addr;
  assign dreq_size   = a_size;
  assign dreq_strobe = a_strobe;
  assign dreq_data   = a_data;

  always_ff @(posedge clk) begin
    if (issue) begin
      a_addr     <= in_addr;
      a_size     <= in_size;
      a_unsigned <= in_unsigned;
      a_strobe   <= strobe_calc;
      a_data     <= data_calc;
      a_rd       <= in_rd;
      a_regwrite <= in_regwrite;
      a_load     <= in_load;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
      out_misalign <= 1'b0;
    end else begin
      state        <= state_next;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
      out_misalign <= 1'b0;
      if (state == IDLE) begin
        if (in_valid && !is_mem) begin
          out_valid    <= 1'b1;
          out_result   <= in_alu;
          out_rd       <= in_rd;
          out_regwrite <= in_regwrite;
        end else if (is_mem && !aligned) begin
          out_valid    <= 1'b1;
          out_rd       <= in_rd;
          out_misalign <= 1'b1;
        end
      end else if (dresp_ok) begin
        out_valid    <= 1'b1;
        out_result   <= a_load ? load_value : 64'd0;
        out_rd       <= a_rd;
        out_regwrite <= a_load && a_regwrite;
      end
    end
  end

endmodule
